// File: rtl/inv_park_seq.sv
// -----------------------------------------------------------------------------
// inv_park_seq
//   Inverse Park transform for the FOC voltage path. Rotates the PI outputs
//   (Vd, Vq) into the stationary frame for the SVPWM stage:
//       Valpha = Vd*cos - Vq*sin
//       Vbeta  = Vd*sin + Vq*cos          (sin/cos in Q1.15)
//   A single signed multiplier is shared over the four products, one product
//   per clock. A rising edge on iIp_en starts a transform; the result appears
//   on oValpha/oVbeta five clocks later together with a 1-cycle oIp_done pulse.
//
// Configuration macro:
//   INV_PARK_SAT_EN  defined   -> shifted result clamped to [-2^(DW-1), 2^(DW-1)-1]
//                    undefined -> shifted result truncated to DW bits (wraps),
//                                 matching the forward Park block.
//
// Ports:
//   iClk      in   clock
//   iRst_n    in   asynchronous active-low reset
//   iIp_en    in   start request, rising edge starts one transform
//   iSin      in   signed sin(theta), Q1.15
//   iCos      in   signed cos(theta), Q1.15
//   iVd       in   signed d-axis voltage
//   iVq       in   signed q-axis voltage
//   oValpha   out  signed alpha-axis voltage, registered
//   oVbeta    out  signed beta-axis voltage, registered
//   oIp_done  out  1-cycle pulse, new oValpha/oVbeta valid
//   oBusy     out  high while a transform is in progress
// -----------------------------------------------------------------------------
module inv_park_seq #(
    parameter int DW   = 12,
    parameter int CW   = 16,
    parameter int FRAC = 15
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic                 iIp_en,
    input  logic signed [CW-1:0] iSin,
    input  logic signed [CW-1:0] iCos,
    input  logic signed [DW-1:0] iVd,
    input  logic signed [DW-1:0] iVq,
    output logic signed [DW-1:0] oValpha,
    output logic signed [DW-1:0] oVbeta,
    output logic                 oIp_done,
    output logic                 oBusy
);

    localparam int PW = DW + CW;      // product width
    localparam int AW = DW + CW + 1;  // accumulator width (one guard bit)

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_M0   = 3'd1;
    localparam logic [2:0] ST_M1   = 3'd2;
    localparam logic [2:0] ST_M2   = 3'd3;
    localparam logic [2:0] ST_M3   = 3'd4;
    localparam logic [2:0] ST_FIN  = 3'd5;

`ifdef INV_PARK_SAT_EN
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
`endif

    logic [2:0]           state_r;
    logic                 en_prev_r;
    logic signed [CW-1:0] sin_r;
    logic signed [CW-1:0] cos_r;
    logic signed [DW-1:0] vd_r;
    logic signed [DW-1:0] vq_r;
    logic signed [AW-1:0] acc_a_r;
    logic signed [AW-1:0] acc_b_r;
    logic signed [DW-1:0] valpha_r;
    logic signed [DW-1:0] vbeta_r;
    logic                 done_r;
    logic                 busy_r;

    logic                 start_s;
    logic signed [DW-1:0] mul_a_s;
    logic signed [CW-1:0] mul_b_s;
    logic signed [PW-1:0] prod_s;
    logic signed [AW-1:0] prod_ext_s;

    // Scale an accumulator back to output width: floor shift, then clamp or wrap.
    function automatic logic signed [DW-1:0] conv_fn(input logic signed [AW-1:0] acc);
        logic signed [AW-1:0] sh;
        sh = acc >>> FRAC;
`ifdef INV_PARK_SAT_EN
        if (sh > SAT_MAX) begin
            conv_fn = SAT_MAX[DW-1:0];
        end else if (sh < SAT_MIN) begin
            conv_fn = SAT_MIN[DW-1:0];
        end else begin
            conv_fn = sh[DW-1:0];
        end
`else
        conv_fn = sh[DW-1:0];
`endif
    endfunction

    assign start_s = iIp_en & ~en_prev_r;

    // Select the operand pair for the shared multiplier from the current state.
    always_comb begin
        mul_a_s = {DW{1'b0}};
        mul_b_s = {CW{1'b0}};
        case (state_r)
            ST_M0:   begin mul_a_s = vd_r; mul_b_s = cos_r; end
            ST_M1:   begin mul_a_s = vq_r; mul_b_s = sin_r; end
            ST_M2:   begin mul_a_s = vd_r; mul_b_s = sin_r; end
            ST_M3:   begin mul_a_s = vq_r; mul_b_s = cos_r; end
            default: begin mul_a_s = {DW{1'b0}}; mul_b_s = {CW{1'b0}}; end
        endcase
    end

    // Shared signed multiplier, sign-extended to accumulator width.
    always_comb begin
        prod_s     = mul_a_s * mul_b_s;
        prod_ext_s = {prod_s[PW-1], prod_s};
    end

    // Sequencer: operand capture, four multiply-accumulate steps, output update.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_r   <= ST_IDLE;
            en_prev_r <= 1'b0;
            sin_r     <= {CW{1'b0}};
            cos_r     <= {CW{1'b0}};
            vd_r      <= {DW{1'b0}};
            vq_r      <= {DW{1'b0}};
            acc_a_r   <= {AW{1'b0}};
            acc_b_r   <= {AW{1'b0}};
            valpha_r  <= {DW{1'b0}};
            vbeta_r   <= {DW{1'b0}};
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            en_prev_r <= iIp_en;
            done_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // Edges seen in any other state are dropped, not queued.
                    if (start_s) begin
                        sin_r   <= iSin;
                        cos_r   <= iCos;
                        vd_r    <= iVd;
                        vq_r    <= iVq;
                        busy_r  <= 1'b1;
                        state_r <= ST_M0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_M0: begin
                    acc_a_r <= prod_ext_s;
                    state_r <= ST_M1;
                end
                ST_M1: begin
                    acc_a_r <= acc_a_r - prod_ext_s;
                    state_r <= ST_M2;
                end
                ST_M2: begin
                    acc_b_r <= prod_ext_s;
                    state_r <= ST_M3;
                end
                ST_M3: begin
                    acc_b_r <= acc_b_r + prod_ext_s;
                    state_r <= ST_FIN;
                end
                ST_FIN: begin
                    valpha_r <= conv_fn(acc_a_r);
                    vbeta_r  <= conv_fn(acc_b_r);
                    done_r   <= 1'b1;
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign oValpha  = valpha_r;
    assign oVbeta   = vbeta_r;
    assign oIp_done = done_r;
    assign oBusy    = busy_r;

endmodule

// File: tb/tb_inv_park_seq.sv
// -----------------------------------------------------------------------------
// tb_inv_park_seq
//   Directed-vector bench for inv_park_seq. Inputs change on the falling edge,
//   outputs are sampled on the falling edge; k counts falling edges after the
//   rising edge that sampled the start request (k=5 is the done cycle).
// -----------------------------------------------------------------------------
module tb_inv_park_seq;

    logic               iClk;
    logic               iRst_n;
    logic               iIp_en;
    logic signed [15:0] iSin;
    logic signed [15:0] iCos;
    logic signed [11:0] iVd;
    logic signed [11:0] iVq;
    logic signed [11:0] oValpha;
    logic signed [11:0] oVbeta;
    logic               oIp_done;
    logic               oBusy;

    int n_cmp;
    int n_bad;

`ifdef INV_PARK_SAT_EN
    localparam logic signed [11:0] DIAG_VA = 12'sd2047;
`else
    localparam logic signed [11:0] DIAG_VA = -12'sd1202;
`endif

    inv_park_seq dut (
        .iClk     (iClk),
        .iRst_n   (iRst_n),
        .iIp_en   (iIp_en),
        .iSin     (iSin),
        .iCos     (iCos),
        .iVd      (iVd),
        .iVq      (iVq),
        .oValpha  (oValpha),
        .oVbeta   (oVbeta),
        .oIp_done (oIp_done),
        .oBusy    (oBusy)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic set_ops(input logic signed [15:0] s, input logic signed [15:0] c,
                           input logic signed [11:0] d, input logic signed [11:0] q);
        iSin = s;
        iCos = c;
        iVd  = d;
        iVq  = q;
    endtask

    task automatic test_reset();
        iRst_n = 1'b0;
        set_ops(16'sd0, 16'sd32767, -12'sd1000, 12'sd100);
        iIp_en = 1'b1;   // high across reset release: must count as a rising edge
        repeat (2) @(negedge iClk);
        n_cmp++; if (oValpha !== 12'sd0) begin n_bad++; $display("FAIL reset_va: got %0d expected 0", oValpha); end
        n_cmp++; if (oVbeta !== 12'sd0) begin n_bad++; $display("FAIL reset_vb: got %0d expected 0", oVbeta); end
        n_cmp++; if (oIp_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0b expected 0", oIp_done); end
        n_cmp++; if (oBusy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b expected 0", oBusy); end
        iRst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge iClk);
            if (k == 0) iIp_en = 1'b0;
            n_cmp++;
            if (oIp_done !== (k == 5)) begin n_bad++; $display("FAIL rel_done k=%0d: got %0b expected %0b", k, oIp_done, (k == 5)); end
            if (k == 5) begin
                n_cmp++; if (oValpha !== -12'sd1000) begin n_bad++; $display("FAIL rel_va: got %0d expected -1000", oValpha); end
                n_cmp++; if (oVbeta !== 12'sd99) begin n_bad++; $display("FAIL rel_vb: got %0d expected 99", oVbeta); end
            end
        end
    endtask

    task automatic test_unit();
        @(negedge iClk);
        set_ops(16'sd0, 16'sd32767, 12'sd1000, 12'sd0);
        iIp_en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge iClk);
            if (k == 0) iIp_en = 1'b0;
            n_cmp++;
            if (oIp_done !== (k == 5)) begin n_bad++; $display("FAIL unit_done k=%0d: got %0b expected %0b", k, oIp_done, (k == 5)); end
            if (k == 5) begin
                n_cmp++; if (oValpha !== 12'sd999) begin n_bad++; $display("FAIL unit_va: got %0d expected 999", oValpha); end
                n_cmp++; if (oVbeta !== 12'sd0) begin n_bad++; $display("FAIL unit_vb: got %0d expected 0", oVbeta); end
            end
        end
    endtask

    task automatic test_rot90();
        @(negedge iClk);
        set_ops(16'sd32767, 16'sd0, 12'sd500, -12'sd300);
        iIp_en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge iClk);
            if (k == 0) iIp_en = 1'b0;
            if (k == 1) set_ops(16'sd1234, -16'sd999, -12'sd7, 12'sd77); // operands are held internally
            n_cmp++;
            if (oBusy !== (k < 5)) begin n_bad++; $display("FAIL rot_busy k=%0d: got %0b expected %0b", k, oBusy, (k < 5)); end
            n_cmp++;
            if (oIp_done !== (k == 5)) begin n_bad++; $display("FAIL rot_done k=%0d: got %0b expected %0b", k, oIp_done, (k == 5)); end
            if (k >= 5) begin
                n_cmp++; if (oValpha !== 12'sd299) begin n_bad++; $display("FAIL rot_va k=%0d: got %0d expected 299", k, oValpha); end
                n_cmp++; if (oVbeta !== 12'sd499) begin n_bad++; $display("FAIL rot_vb k=%0d: got %0d expected 499", k, oVbeta); end
            end
        end
    endtask

    task automatic test_ignore_edge();
        int dones;
        dones = 0;
        @(negedge iClk);
        set_ops(16'sd0, 16'sd32767, 12'sd1000, 12'sd0);
        iIp_en = 1'b1;
        for (int k = 0; k < 13; k++) begin
            @(negedge iClk);
            if (oIp_done === 1'b1) dones++;
            n_cmp++;
            if (oIp_done !== (k == 5 || k == 11)) begin n_bad++; $display("FAIL ign_done k=%0d: got %0b expected %0b", k, oIp_done, (k == 5 || k == 11)); end
            if (k == 5) begin
                n_cmp++; if (oValpha !== 12'sd999) begin n_bad++; $display("FAIL ign_va1: got %0d expected 999", oValpha); end
                n_cmp++; if (oVbeta !== 12'sd0) begin n_bad++; $display("FAIL ign_vb1: got %0d expected 0", oVbeta); end
            end
            if (k == 11) begin
                n_cmp++; if (oValpha !== DIAG_VA) begin n_bad++; $display("FAIL diag_va: got %0d expected %0d", oValpha, DIAG_VA); end
                n_cmp++; if (oVbeta !== 12'sd0) begin n_bad++; $display("FAIL diag_vb: got %0d expected 0", oVbeta); end
            end
            // edge while busy (before T2), then a legal edge right after done (diag vector)
            case (k)
                0: iIp_en = 1'b0;
                1: iIp_en = 1'b1;
                2: iIp_en = 1'b0;
                5: begin set_ops(-16'sd23170, 16'sd23170, 12'sd2047, 12'sd2047); iIp_en = 1'b1; end
                6: iIp_en = 1'b0;
                default: iIp_en = iIp_en;
            endcase
        end
        n_cmp++; if (dones !== 2) begin n_bad++; $display("FAIL ign_count: got %0d expected 2", dones); end
    endtask

    task automatic test_reset_mid();
        @(negedge iClk);
        set_ops(16'sd0, 16'sd32767, 12'sd1000, 12'sd0);
        iIp_en = 1'b1;
        repeat (3) @(negedge iClk);   // k = 0..2
        iIp_en = 1'b0;
        iRst_n = 1'b0;
        #1;
        n_cmp++; if (oValpha !== 12'sd0) begin n_bad++; $display("FAIL mid_va: got %0d expected 0", oValpha); end
        n_cmp++; if (oVbeta !== 12'sd0) begin n_bad++; $display("FAIL mid_vb: got %0d expected 0", oVbeta); end
        n_cmp++; if (oBusy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %0b expected 0", oBusy); end
        for (int k = 0; k < 4; k++) begin
            @(negedge iClk);
            if (k == 1) iRst_n = 1'b1;
            n_cmp++; if (oIp_done !== 1'b0) begin n_bad++; $display("FAIL mid_nodone k=%0d: got %0b expected 0", k, oIp_done); end
        end
        iIp_en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge iClk);
            if (k == 0) iIp_en = 1'b0;
            n_cmp++;
            if (oIp_done !== (k == 5)) begin n_bad++; $display("FAIL mid_done k=%0d: got %0b expected %0b", k, oIp_done, (k == 5)); end
            if (k == 5) begin
                n_cmp++; if (oValpha !== 12'sd999) begin n_bad++; $display("FAIL mid_va2: got %0d expected 999", oValpha); end
            end
        end
    endtask

    task automatic test_hold_high();
        int dones;
        dones = 0;
        @(negedge iClk);
        set_ops(16'sd32767, 16'sd0, 12'sd500, -12'sd300);
        iIp_en = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(negedge iClk);
            if (k == 19) iIp_en = 1'b0;
            if (oIp_done === 1'b1) dones++;
        end
        n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL hold_count: got %0d expected 1", dones); end
        n_cmp++; if (oValpha !== 12'sd299) begin n_bad++; $display("FAIL hold_va: got %0d expected 299", oValpha); end
        n_cmp++; if (oVbeta !== 12'sd499) begin n_bad++; $display("FAIL hold_vb: got %0d expected 499", oVbeta); end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        iRst_n = 1'b0;
        iIp_en = 1'b0;
        set_ops(16'sd0, 16'sd0, 12'sd0, 12'sd0);
        test_reset();
        test_unit();
        test_rot90();
        test_ignore_edge();
        test_reset_mid();
        test_hold_high();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
